// File: rtl/dist_report_sched_pkg.sv
// ============================================================================
// Module : dist_sched_pkg
// Brief  : FSM state encoding and shared constants for dist_report_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dist_sched_pkg;

    localparam int DIST_DW = 19;

    // Timeout marker placed on rpt_data when no echo came back in time.
    localparam logic [DIST_DW-1:0] DIST_INVALID = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIG   = 3'd1,
        WAIT   = 3'd2,
        FILT   = 3'd3,
        SEND_U = 3'd4,
        SEND_N = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dist_report_sched_if.sv
// ============================================================================
// Module : dist_report_sched_if
// Brief  : Report bus shared by the UART and net sinks (one word, two valids).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dist_report_sched_if #(
    parameter int DW = 19
);
    logic [DW-1:0] rpt_data;
    logic          rpt_err;
    logic          uart_valid;
    logic          uart_ready;
    logic          net_valid;
    logic          net_ready;

    modport master (
        output rpt_data, rpt_err, uart_valid, net_valid,
        input  uart_ready, net_ready
    );

    modport slave (
        input  rpt_data, rpt_err, uart_valid, net_valid,
        output uart_ready, net_ready
    );
endinterface

`default_nettype wire

// File: rtl/dist_report_sched_median3.sv
// ============================================================================
// Module : dist_median3
// Brief  : 3-deep sample window with median compare network; present only
//          when MEDIAN3_FILTER_EN is defined. Passes samples through until
//          the window is full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MEDIAN3_FILTER_EN
module dist_median3 #(
    parameter int DW = 19
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] r_s0;
    logic [DW-1:0] r_s1;
    logic [DW-1:0] r_s2;
    logic [1:0]    r_fill;

    function automatic logic [DW-1:0] f_med3(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c
    );
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0   <= '0;
            r_s1   <= '0;
            r_s2   <= '0;
            r_fill <= 2'd0;
        end else if (push) begin
            r_s0 <= din;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
            if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
        end
    end

    assign dout = (r_fill == 2'd3) ? f_med3(r_s0, r_s1, r_s2) : r_s0;

endmodule
`endif

`default_nettype wire

// File: rtl/dist_report_sched.sv
// ============================================================================
// Module : dist_report_sched
// Brief  : Periodic ranging sequencer; reports each distance to the UART sink
//          then the net sink. Optional median filter: MEDIAN3_FILTER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dist_report_sched
    import dist_sched_pkg::*;
#(
    parameter int DW           = DIST_DW,
    parameter int PERIOD_CYC   = 5_000_000,
    parameter int ECHO_TMO_CYC = 1_500_000,
    parameter int ACK_TMO_CYC  = 50_000
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                meas_start,
    input  logic                meas_done,
    input  logic [DW-1:0]       meas_data,
    dist_report_sched_if.master rpt,
    output logic [DW-1:0]       last_dist,
    output logic [1:0]          sink_drop,
    output logic [7:0]          overrun_cnt
);

    localparam int TW      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TMO_MAX = (ECHO_TMO_CYC > ACK_TMO_CYC) ? ECHO_TMO_CYC : ACK_TMO_CYC;
    localparam int CW      = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;

    localparam logic [TW-1:0] c_tick_last    = TW'(PERIOD_CYC - 1);
    localparam logic [CW-1:0] c_echo_last    = CW'(ECHO_TMO_CYC - 1);
    localparam logic [CW-1:0] c_ack_last     = CW'(ACK_TMO_CYC - 1);
    localparam logic [DW-1:0] c_dist_invalid = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [CW-1:0] r_cnt;
    logic          w_tick;
    logic          w_load;
    logic          w_load_err;
    logic [1:0]    w_drop;
    logic [DW-1:0] r_rpt_data;
    logic          r_rpt_err;
    logic [DW-1:0] r_last_dist;
    logic [1:0]    r_sink_drop;
    logic [7:0]    r_overrun;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Shared timeout counter: restarts on every state change, so it measures
    // echo wait in WAIT and sink hold-off in SEND_U/SEND_N.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                       r_cnt <= '0;
        else if (w_state_nxt != r_state) r_cnt <= '0;
        else                             r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        meas_start     = 1'b0;
        rpt.uart_valid = 1'b0;
        rpt.net_valid  = 1'b0;
        w_load         = 1'b0;
        w_load_err     = 1'b0;
        w_drop         = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_tick) w_state_nxt = TRIG;
            end
            TRIG: begin
                meas_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (meas_done || (r_cnt == c_echo_last)) begin
                    w_load     = 1'b1;
                    w_load_err = !meas_done;
`ifdef MEDIAN3_FILTER_EN
                    w_state_nxt = FILT;
`else
                    w_state_nxt = SEND_U;
`endif
                end
            end
`ifdef MEDIAN3_FILTER_EN
            FILT: begin
                w_state_nxt = SEND_U;
            end
`endif
            SEND_U: begin
                rpt.uart_valid = 1'b1;
                if (rpt.uart_ready) begin
                    w_state_nxt = SEND_N;
                end else if (r_cnt == c_ack_last) begin
                    w_drop[0]   = 1'b1;
                    w_state_nxt = SEND_N;
                end
            end
            SEND_N: begin
                rpt.net_valid = 1'b1;
                if (rpt.net_ready) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_ack_last) begin
                    w_drop[1]   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEDIAN3_FILTER_EN
    logic          r_err;
    logic [DW-1:0] w_med;

    // Timeout samples never enter the window.
    dist_median3 #(.DW(DW)) u_median3 (
        .clk  (clk),
        .rstn (rstn),
        .push (w_load && meas_done),
        .din  (meas_data),
        .dout (w_med)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_err <= 1'b0;
        else if (w_load) r_err <= w_load_err;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rpt_data  <= '0;
            r_rpt_err   <= 1'b0;
            r_last_dist <= '0;
        end else if (r_state == FILT) begin
            r_rpt_data <= r_err ? c_dist_invalid : w_med;
            r_rpt_err  <= r_err;
            if (!r_err) r_last_dist <= w_med;
        end
    end
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rpt_data  <= '0;
            r_rpt_err   <= 1'b0;
            r_last_dist <= '0;
        end else if (w_load) begin
            r_rpt_data <= w_load_err ? c_dist_invalid : meas_data;
            r_rpt_err  <= w_load_err;
            if (!w_load_err) r_last_dist <= meas_data;
        end
    end
`endif

    // A tick seen outside IDLE, including the cycle that returns to IDLE, is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sink_drop <= 2'b00;
            r_overrun   <= 8'd0;
        end else begin
            r_sink_drop <= w_drop;
            if (w_tick && (r_state != IDLE) && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
        end
    end

    assign rpt.rpt_data = r_rpt_data;
    assign rpt.rpt_err  = r_rpt_err;
    assign last_dist    = r_last_dist;
    assign sink_drop    = r_sink_drop;
    assign overrun_cnt  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_dist_report_sched.sv
// ============================================================================
// Module : tb_dist_report_sched
// Brief  : Directed self-checking bench for dist_report_sched (both builds,
//          with or without MEDIAN3_FILTER_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dist_report_sched;

    localparam int DW = 19;
`ifdef MEDIAN3_FILTER_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          meas_start;
    logic          meas_done;
    logic [DW-1:0] meas_data;
    logic [DW-1:0] last_dist;
    logic [1:0]    sink_drop;
    logic [7:0]    overrun_cnt;

    logic          rstn2;
    logic          meas_start2;
    logic          meas_done2;
    logic [DW-1:0] meas_data2;
    logic [DW-1:0] last_dist2;
    logic [1:0]    sink_drop2;
    logic [7:0]    overrun_cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dist_report_sched_if #(.DW(DW)) ifc ();
    dist_report_sched_if #(.DW(DW)) ifc2 ();

    dist_report_sched #(
        .DW(DW), .PERIOD_CYC(100), .ECHO_TMO_CYC(40), .ACK_TMO_CYC(8)
    ) u_dut (
        .clk(clk), .rstn(rstn), .meas_start(meas_start), .meas_done(meas_done),
        .meas_data(meas_data), .rpt(ifc.master), .last_dist(last_dist),
        .sink_drop(sink_drop), .overrun_cnt(overrun_cnt)
    );

    // Short period so every measurement spans several ticks.
    dist_report_sched #(
        .DW(DW), .PERIOD_CYC(10), .ECHO_TMO_CYC(40), .ACK_TMO_CYC(8)
    ) u_dut2 (
        .clk(clk), .rstn(rstn2), .meas_start(meas_start2), .meas_done(meas_done2),
        .meas_data(meas_data2), .rpt(ifc2.master), .last_dist(last_dist2),
        .sink_drop(sink_drop2), .overrun_cnt(overrun_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (meas_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            cnt;
        logic          acc;
        logic          bad;
        logic [DW-1:0] smp [4];
        logic [DW-1:0] exp_rpt [4];

        smp[0] = 19'd100; smp[1] = 19'd900; smp[2] = 19'd300; smp[3] = 19'd50;
`ifdef MEDIAN3_FILTER_EN
        exp_rpt[0] = 19'd100; exp_rpt[1] = 19'd900; exp_rpt[2] = 19'd300; exp_rpt[3] = 19'd300;
`else
        exp_rpt[0] = 19'd100; exp_rpt[1] = 19'd900; exp_rpt[2] = 19'd300; exp_rpt[3] = 19'd50;
`endif

        rstn = 1'b0; rstn2 = 1'b0;
        meas_done = 1'b0; meas_data = '0;
        meas_done2 = 1'b0; meas_data2 = '0;
        ifc.uart_ready = 1'b1;  ifc.net_ready = 1'b1;
        ifc2.uart_ready = 1'b0; ifc2.net_ready = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_start",   32'(meas_start), 32'd0);
        chk("rst_uvalid",  32'(ifc.uart_valid), 32'd0);
        chk("rst_nvalid",  32'(ifc.net_valid), 32'd0);
        chk("rst_data",    32'(ifc.rpt_data), 32'd0);
        chk("rst_err",     32'(ifc.rpt_err), 32'd0);
        chk("rst_last",    32'(last_dist), 32'd0);
        chk("rst_drop",    32'(sink_drop), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);

        // First tick lands on cycle PERIOD after release
        rstn = 1'b1;
        repeat (99) step();
        chk("tick_early", 32'(meas_start), 32'd0);
        step();
        chk("tick_start", 32'(meas_start), 32'd1);

        // 1: normal measurement, both sinks ready
        repeat (10) step();
        meas_done = 1'b1; meas_data = 19'd1234;
        step();
        meas_done = 1'b0;
        repeat (LAT - 1) step();
        chk("t1_uvalid", 32'(ifc.uart_valid), 32'd1);
        chk("t1_nvalid", 32'(ifc.net_valid), 32'd0);
        chk("t1_data",   32'(ifc.rpt_data), 32'd1234);
        chk("t1_err",    32'(ifc.rpt_err), 32'd0);
        chk("t1_last",   32'(last_dist), 32'd1234);
        step();
        chk("t1_uvalid2", 32'(ifc.uart_valid), 32'd0);
        chk("t1_nvalid2", 32'(ifc.net_valid), 32'd1);
        chk("t1_data2",   32'(ifc.rpt_data), 32'd1234);
        step();
        chk("t1_nvalid3", 32'(ifc.net_valid), 32'd0);
        wait_start(n);
        chk("t1_period", 32'(n), 32'(88 - LAT));

        // 2: echo timeout
        repeat (39 + LAT) step();
        chk("t2_not_yet", 32'(ifc.uart_valid), 32'd0);
        step();
        chk("t2_uvalid", 32'(ifc.uart_valid), 32'd1);
        chk("t2_err",    32'(ifc.rpt_err), 32'd1);
        chk("t2_data",   32'(ifc.rpt_data), 32'h7FFFF);
        chk("t2_last",   32'(last_dist), 32'd1234);
        step();
        chk("t2_nvalid", 32'(ifc.net_valid), 32'd1);
        chk("t2_err2",   32'(ifc.rpt_err), 32'd1);
        step();
        ifc.uart_ready = 1'b0;
        wait_start(n);
        chk("t2_period", 32'(n), 32'(58 - LAT));

        // 3: UART backpressure until ack timeout
        step();
        meas_done = 1'b1; meas_data = 19'd555;
        step();
        meas_done = 1'b0;
        repeat (LAT - 1) step();
        cnt = 0; bad = 1'b0;
        while (ifc.uart_valid === 1'b1 && cnt < 20) begin
            if (ifc.rpt_data !== 19'd555) bad = 1'b1;
            cnt++;
            step();
        end
        chk("t3_ulen",   32'(cnt), 32'd8);
        chk("t3_stable", 32'(bad), 32'd0);
        chk("t3_drop",   32'(sink_drop), 32'b01);
        chk("t3_nvalid", 32'(ifc.net_valid), 32'd1);
        chk("t3_data",   32'(ifc.rpt_data), 32'd555);
        step();
        chk("t3_drop_end", 32'(sink_drop), 32'd0);
        chk("t3_nvalid2",  32'(ifc.net_valid), 32'd0);
        chk("t3_last",     32'(last_dist), 32'd555);
        ifc.uart_ready = 1'b1;

        // 4: overrun on the short-period instance
        rstn2 = 1'b1;
        repeat (10) step();
        chk("t4_start1", 32'(meas_start2), 32'd1);
        repeat (34 - LAT) step();
        meas_done2 = 1'b1; meas_data2 = 19'd77;
        step();
        meas_done2 = 1'b0;
        acc = 1'b0;
        repeat (24 + LAT) begin
            step();
            acc = acc | meas_start2;
        end
        chk("t4_no_start", 32'(acc), 32'd0);
        step();
        chk("t4_start2",   32'(meas_start2), 32'd1);
        chk("t4_overrun5", 32'(overrun_cnt2), 32'd5);
        chk("t4_last",     32'(last_dist2), 32'd77);
        repeat (60) step();
        chk("t4_start3",    32'(meas_start2), 32'd1);
        chk("t4_overrun10", 32'(overrun_cnt2), 32'd10);
        repeat (3600) step();
        chk("t4_sat", 32'(overrun_cnt2), 32'd255);
        chk("t4_main_overrun", 32'(overrun_cnt), 32'd0);

        // 5: asynchronous reset while offering to the UART sink
        ifc.uart_ready = 1'b0;
        wait_start(n);
        chk("t5_found", 32'(n < 300), 32'd1);
        step();
        meas_done = 1'b1; meas_data = 19'd999;
        step();
        meas_done = 1'b0;
        repeat (LAT - 1) step();
        chk("t5_uvalid", 32'(ifc.uart_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_uvalid0", 32'(ifc.uart_valid), 32'd0);
        chk("t5_data0",   32'(ifc.rpt_data), 32'd0);
        chk("t5_last0",   32'(last_dist), 32'd0);
        chk("t5_start0",  32'(meas_start), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        ifc.uart_ready = 1'b1;
        acc = 1'b0;
        repeat (99) begin
            step();
            acc = acc | meas_start | ifc.uart_valid | ifc.net_valid;
        end
        chk("t5_quiet", 32'(acc), 32'd0);
        step();
        chk("t5_start", 32'(meas_start), 32'd1);

        // 6: sample sequence (median in the filtered build)
        for (int m = 0; m < 4; m++) begin
            if (m > 0) begin
                wait_start(n);
                chk("t6_found", 32'(n < 300), 32'd1);
            end
            step();
            meas_done = 1'b1; meas_data = smp[m];
            step();
            meas_done = 1'b0;
            repeat (LAT - 1) step();
            chk("t6_uvalid", 32'(ifc.uart_valid), 32'd1);
            chk("t6_data",   32'(ifc.rpt_data), 32'(exp_rpt[m]));
            chk("t6_last",   32'(last_dist), 32'(exp_rpt[m]));
            step();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
